// File: rtl/seq_det_pkg.sv
// Shared types and reset constants for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  localparam logic [3:0] DEF_PAT = 4'b1011;
  localparam int         DEF_LEN = 4;
  localparam logic       DEF_OVL = 1'b1;

endpackage

// File: rtl/seq_det_satcnt.sv
// Saturating up-counter; clr beats inc, holds at all-ones.
module seq_det_satcnt
  import seq_det_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial pattern detector with Mealy and registered match outputs.
// Optional saturating match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_prog
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 16,
  localparam int LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_valid,
  input  logic               x,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pat,
  input  logic [LW-1:0]      cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic               y_q,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LW-1:0]      MAX_LEN_L = LW'(MAX_LEN);
  localparam logic [LW-1:0]      ONE_L     = LW'(1);
  localparam logic [LW-1:0]      DEF_LEN_L = LW'(DEF_LEN);
  localparam logic [MAX_LEN-1:0] DEF_PAT_W = MAX_LEN'(DEF_PAT);

  logic [MAX_LEN-1:0] pat_r;
  logic [LW-1:0]      len_r;
  logic               ovl_r;

  // Only the len-1 bits preceding the current one ever take part in a compare.
  logic [MAX_LEN-2:0] hist;
  logic [LW-1:0]      fill;
  state_t             state;

  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;
  logic [LW-1:0]      fill_inc;
  logic               hit;
  logic               cfg_ok;

  function automatic state_t state_for(input logic [LW-1:0] f, input logic [LW-1:0] l);
    return (f >= l - ONE_L) ? ARMED : FILL;
  endfunction

  assign cand = {hist, x};

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LW'(i) < len_r);
    end
  end

  assign hit      = ((cand ^ pat_r) & mask) == '0;
  assign cfg_ok   = (cfg_len != '0) && (cfg_len <= MAX_LEN_L);
  assign fill_inc = (fill == len_r) ? fill : fill + ONE_L;

  assign y = (state == ARMED) && x_valid && !cfg_load && !rst && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r   <= DEF_PAT_W;
      len_r   <= DEF_LEN_L;
      ovl_r   <= DEF_OVL;
      hist    <= '0;
      fill    <= '0;
      state   <= state_for('0, DEF_LEN_L);
      y_q     <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      y_q     <= y;
      cfg_err <= cfg_load && !cfg_ok;
      if (cfg_load) begin
        // A rejected load leaves both config and history untouched.
        if (cfg_ok) begin
          pat_r <= cfg_pat;
          len_r <= cfg_len;
          ovl_r <= cfg_overlap;
          hist  <= '0;
          fill  <= '0;
          state <= state_for('0, cfg_len);
        end
      end else if (x_valid) begin
        if (y && !ovl_r) begin
          hist  <= '0;
          fill  <= '0;
          state <= state_for('0, len_r);
        end else begin
          hist  <= cand[MAX_LEN-2:0];
          fill  <= fill_inc;
          state <= state_for(fill_inc, len_r);
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  seq_det_satcnt #(
    .W(CNT_W)
  ) u_satcnt (
    .clk(clk),
    .rst(rst),
    .inc(y),
    .clr(cnt_clr),
    .cnt(match_cnt)
  );
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_cnt      = '0;
`endif

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog with a sequence-level reference model.
module tb_seq_detector_prog;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LW      = 4;
`ifdef SEQ_DET_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               x_valid;
  logic               x;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LW-1:0]      cfg_len;
  logic               cfg_overlap;
  logic               cnt_clr;
  logic               y;
  logic               y_q;
  logic               cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  seq_detector_prog #(
    .MAX_LEN(MAX_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_valid(x_valid),
    .x(x),
    .cfg_load(cfg_load),
    .cfg_pat(cfg_pat),
    .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr),
    .y(y),
    .y_q(y_q),
    .cfg_err(cfg_err),
    .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bits received since the last history clear, plus active config.
  bit         mq[$];
  logic [7:0] m_pat = 8'b0000_1011;
  int         m_len = 4;
  bit         m_ovl = 1'b1;
  bit         m_yq  = 1'b0;
  bit         m_err = 1'b0;
  int         m_cnt = 0;

  function automatic bit model_match(input bit xb);
    bit s[$];
    s = mq;
    s.push_back(xb);
    if (s.size() < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      if (s[s.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit ey;
    ey = !rst && x_valid && !cfg_load && model_match(x);
    chk("y", {31'b0, y}, {31'b0, ey});
    chk("y_q", {31'b0, y_q}, {31'b0, m_yq});
    chk("cfg_err", {31'b0, cfg_err}, {31'b0, m_err});
    chk("match_cnt", 32'(match_cnt), m_cnt);
    if (rst) begin
      m_pat = 8'b0000_1011;
      m_len = 4;
      m_ovl = 1'b1;
      m_yq  = 1'b0;
      m_err = 1'b0;
      m_cnt = 0;
      mq.delete();
    end else begin
      m_yq  = ey;
      m_err = cfg_load && (cfg_len == 0 || cfg_len > MAX_LEN);
      if (CNT_ON) begin
        if (cnt_clr) m_cnt = 0;
        else if (ey && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
      if (cfg_load) begin
        if (!m_err) begin
          m_pat = cfg_pat;
          m_len = int'(cfg_len);
          m_ovl = cfg_overlap;
          mq.delete();
        end
      end else if (x_valid) begin
        if (ey && !m_ovl) begin
          mq.delete();
        end else begin
          mq.push_back(x);
          if (mq.size() > MAX_LEN) void'(mq.pop_front());
        end
      end
    end
  end

  task automatic step(input logic v, input logic b, input logic clr, input logic ey);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    cfg_load = 1'b0;
    x_valid  = v;
    x        = b;
    cnt_clr  = clr;
    #2;
    chk("y_lit", {31'b0, y}, {31'b0, ey});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Loads always collide with a valid bit to show the sample is discarded.
  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic clr);
    @(posedge clk);
    #1;
    rst         = 1'b0;
    cfg_load    = 1'b1;
    cfg_pat     = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = clr;
    x_valid     = 1'b1;
    x           = 1'b1;
    #2;
    chk("y_load", {31'b0, y}, 32'd0);
  endtask

  task automatic do_rst();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    cfg_load = 1'b0;
    cnt_clr  = 1'b0;
    x_valid  = 1'b1;
    x        = 1'b1;
    #2;
    chk("y_rst", {31'b0, y}, 32'd0);
  endtask

  // bits/ey are sent MSB first.
  task automatic stream(input int n, input logic [15:0] bits, input logic [15:0] ey);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, ey[i]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    x_valid     = 1'b0;
    x           = 1'b0;
    cfg_load    = 1'b0;
    cfg_pat     = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    chk("rst_y_q", {31'b0, y_q}, 32'd0);
    chk("rst_cfg_err", {31'b0, cfg_err}, 32'd0);
    chk("rst_match_cnt", 32'(match_cnt), 32'd0);

    // Default 1011 overlapping: matches on bits 4 and 7.
    stream(7, 16'b1011011, 16'b0001001);
    idle();
    chk("t1_y_q", {31'b0, y_q}, 32'd1);
    chk("t1_cnt", 32'(match_cnt), CNT_ON ? 32'd2 : 32'd0);

    // Non-overlapping: history cleared after bit 4.
    load(8'b0000_1011, 4'd4, 1'b0, 1'b1);
    stream(7, 16'b1011011, 16'b0001000);
    idle();
    chk("t2_cnt", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Bubbles between bits 2 and 3.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    chk("t3_cnt", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);

    // Rejected loads: len 0 and len 9.
    load(8'b0000_1011, 4'd0, 1'b1, 1'b0);
    idle();
    chk("t4_err0_pulse", {31'b0, cfg_err}, 32'd1);
    idle();
    chk("t4_err0_clear", {31'b0, cfg_err}, 32'd0);
    load(8'b0000_0001, 4'd9, 1'b0, 1'b0);
    idle();
    chk("t4_err9_pulse", {31'b0, cfg_err}, 32'd1);
    idle();
    chk("t4_err9_clear", {31'b0, cfg_err}, 32'd0);
    stream(4, 16'b1011, 16'b0001);

    // Single-bit pattern "1": saturation, then clear colliding with a match.
    load(8'b0000_0001, 4'd1, 1'b1, 1'b1);
    stream(6, 16'b110111, 16'b110111);
    idle();
    chk("t5_sat", 32'(match_cnt), CNT_ON ? 32'd3 : 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle();
    chk("t5_clr_wins", 32'(match_cnt), 32'd0);

    // Reset mid-pattern discards the partial 1,0,1.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b1);
    stream(3, 16'b101, 16'b000);
    do_rst();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    stream(4, 16'b1011, 16'b0001);
    idle();
    chk("t6_cnt", 32'(match_cnt), CNT_ON ? 32'd1 : 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
